// File: rtl/jtag_host_pkg.sv
// Shared definitions for the JTAG host driver: command encodings, FSM states
// and the fixed TMS sequences that walk the TAP between Run-Test/Idle and the
// shift states. Patterns are stored LSB-first, so bit 0 is driven first.
package jtag_host_pkg;

    localparam logic [1:0] OP_TAP_RESET = 2'd0;
    localparam logic [1:0] OP_SHIFT_IR  = 2'd1;
    localparam logic [1:0] OP_SHIFT_DR  = 2'd2;
    localparam logic [1:0] OP_RUN_IDLE  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SHIFT,
        ST_POST,
        ST_DONE
    } jtag_state_e;

    // Five ones force Test-Logic-Reset from anywhere, the trailing zero parks in Run-Test/Idle.
    localparam logic [7:0] PRE_RESET_PAT = 8'b0001_1111;
    localparam logic [3:0] PRE_RESET_LEN = 4'd6;
    // Run-Test/Idle -> Select-DR -> Select-IR -> Capture-IR -> Shift-IR
    localparam logic [7:0] PRE_IR_PAT    = 8'b0000_0011;
    localparam logic [3:0] PRE_IR_LEN    = 4'd4;
    // Run-Test/Idle -> Select-DR -> Capture-DR -> Shift-DR
    localparam logic [7:0] PRE_DR_PAT    = 8'b0000_0001;
    localparam logic [3:0] PRE_DR_LEN    = 4'd3;
    // Exit1 -> Update -> Run-Test/Idle
    localparam logic [7:0] POST_PAT      = 8'b0000_0001;
    localparam logic [3:0] POST_LEN      = 4'd2;

    // Preamble TMS pattern; RUN_IDLE clocks with TMS held low.
    function automatic logic [7:0] pre_pat(input logic [1:0] op);
        case (op)
            OP_TAP_RESET: pre_pat = PRE_RESET_PAT;
            OP_SHIFT_IR:  pre_pat = PRE_IR_PAT;
            OP_SHIFT_DR:  pre_pat = PRE_DR_PAT;
            default:      pre_pat = 8'h00;
        endcase
    endfunction

    // Preamble length; RUN_IDLE length comes from the command instead (returns 0 here).
    function automatic logic [3:0] pre_len(input logic [1:0] op);
        case (op)
            OP_TAP_RESET: pre_len = PRE_RESET_LEN;
            OP_SHIFT_IR:  pre_len = PRE_IR_LEN;
            OP_SHIFT_DR:  pre_len = PRE_DR_LEN;
            default:      pre_len = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK divider. While enabled, tck starts low, rises after CLK_DIV clk cycles and
// falls CLK_DIV cycles later. rise_stb/fall_stb are high in the cycle whose
// closing clk edge makes tck rise/fall, so logic clocked on that edge can act
// in lockstep with the TCK transition.
module jtag_tck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tck,
    output logic rise_stb,
    output logic fall_stb
);

    localparam int CW = (2 * CLK_DIV > 2) ? $clog2(2 * CLK_DIV) : 1;

    logic [CW-1:0] cnt;

    assign rise_stb = en && (cnt == CW'(CLK_DIV - 1));
    assign fall_stb = en && (cnt == CW'(2 * CLK_DIV - 1));

    // Phase counter and tck register; disabling restarts the period from a low tck.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            tck <= 1'b0;
        end else if (!en) begin
            cnt <= '0;
            tck <= 1'b0;
        end else begin
            if (fall_stb) begin
                cnt <= '0;
                tck <= 1'b0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            if (rise_stb) tck <= 1'b1;
        end
    end

endmodule

// File: rtl/jtag_host_driver.sv
// On-chip JTAG initiator. Runs one command at a time (TAP reset, IR shift,
// DR shift, idle clocks) as a TMS preamble, an optional shift burst and a
// postamble, then reports the captured TDO bits with a one-cycle rsp_valid.
// tms/tdi change on the clk edge where tck falls (the accept edge for the
// first bit); tdo is sampled on the edge where tck rises.
module jtag_host_driver
    import jtag_host_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int CLK_DIV = 4,
    parameter int LEN_W   = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic              synced,
    output logic              tck,
    output logic              tms,
    output logic              tdi,
    input  logic              tdo
);

    // Bit counter must hold both the data length and the longest fixed preamble.
    localparam int CW = (LEN_W > 3) ? LEN_W : 3;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    jtag_state_e       state;
    logic [1:0]        op;
    logic [CW-1:0]     idx;
    logic [CW-1:0]     pre_last;
    logic [CW-1:0]     sh_last;
    logic [7:0]        tms_pat;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] cap;
    logic [DATA_W-1:0] msk;
    logic [DW-1:0]     dcnt;

    logic              tck_en;
    logic              rise_stb;
    logic              fall_stb;
    logic [LEN_W-1:0]  len_eff;
    logic [7:0]        acc_pat;
    logic [CW-1:0]     acc_pre_last;

    assign busy   = !cmd_ready;
    // TCK only runs while bits are being clocked; DONE waits with tck parked low.
    assign tck_en = busy && (state != ST_DONE);

    jtag_tck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tck_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (tck_en),
        .tck      (tck),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb)
    );

    // Command decode at accept: zero length means one bit, long lengths clamp to DATA_W.
    always_comb begin
        len_eff = cmd_len;
        if (cmd_len == '0) len_eff = LEN_W'(1);
        else if (cmd_len > LEN_W'(DATA_W)) len_eff = LEN_W'(DATA_W);
        acc_pat      = pre_pat(cmd_op);
        acc_pre_last = CW'(pre_len(cmd_op)) - CW'(1);
        if (cmd_op == OP_RUN_IDLE) acc_pre_last = CW'(len_eff) - CW'(1);
    end

    // Command sequencer: walks PRE/SHIFT/POST on TCK strobes, then reports in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            op        <= OP_TAP_RESET;
            idx       <= '0;
            pre_last  <= '0;
            sh_last   <= '0;
            tms_pat   <= '0;
            shreg     <= '0;
            cap       <= '0;
            msk       <= '0;
            dcnt      <= '0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            synced    <= 1'b0;
            tms       <= 1'b1;
            tdi       <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    tdi <= 1'b0;
                    if (cmd_valid) begin
                        state     <= ST_PRE;
                        cmd_ready <= 1'b0;
                        op        <= cmd_op;
                        shreg     <= cmd_data;
                        cap       <= '0;
                        msk       <= '0;
                        idx       <= '0;
                        dcnt      <= '0;
                        pre_last  <= acc_pre_last;
                        sh_last   <= CW'(len_eff) - CW'(1);
                        tms       <= acc_pat[0];
                        tms_pat   <= acc_pat >> 1;
                    end
                end
                ST_PRE: begin
                    if (fall_stb) begin
                        if (idx == pre_last) begin
                            idx <= '0;
                            if (op == OP_SHIFT_IR || op == OP_SHIFT_DR) begin
                                // First data bit; a one-bit shift leaves on this very bit.
                                state <= ST_SHIFT;
                                tdi   <= shreg[0];
                                shreg <= shreg >> 1;
                                msk   <= DATA_W'(1);
                                tms   <= (sh_last == '0);
                            end else begin
                                state <= ST_DONE;
                            end
                        end else begin
                            idx     <= idx + CW'(1);
                            tms     <= tms_pat[0];
                            tms_pat <= tms_pat >> 1;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (rise_stb && tdo) cap <= cap | msk;
                    if (fall_stb) begin
                        if (idx == sh_last) begin
                            state   <= ST_POST;
                            idx     <= '0;
                            tdi     <= 1'b0;
                            tms     <= POST_PAT[0];
                            tms_pat <= POST_PAT >> 1;
                        end else begin
                            idx   <= idx + CW'(1);
                            tdi   <= shreg[0];
                            shreg <= shreg >> 1;
                            msk   <= msk << 1;
                            // Raise TMS on the last bit so its rising edge moves to Exit1.
                            tms   <= ((idx + CW'(1)) == sh_last);
                        end
                    end
                end
                ST_POST: begin
                    if (fall_stb) begin
                        if (idx == CW'(POST_LEN) - CW'(1)) begin
                            state <= ST_DONE;
                        end else begin
                            idx     <= idx + CW'(1);
                            tms     <= tms_pat[0];
                            tms_pat <= tms_pat >> 1;
                        end
                    end
                end
                ST_DONE: begin
                    // Hold off one TCK half-period after the last falling edge.
                    if (dcnt == DW'(CLK_DIV - 1)) begin
                        state     <= ST_IDLE;
                        cmd_ready <= 1'b1;
                        rsp_valid <= 1'b1;
                        rsp_data  <= cap;
                        if (op == OP_TAP_RESET) synced <= 1'b1;
                    end else begin
                        dcnt <= dcnt + DW'(1);
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_host_driver.sv
// Directed bench for jtag_host_driver with a behavioural TAP target
// (4-bit IR capturing 0001, 32-bit DR capturing dr_cap).
module tb_jtag_host_driver;

    localparam int DATA_W  = 32;
    localparam int CLK_DIV = 2;
    localparam int LEN_W   = 6;

    localparam int TLR = 0, RTI = 1, SDS = 2, CDR = 3, SDR = 4, E1D = 5, PDR = 6, E2D = 7;
    localparam int UDR = 8, SIS = 9, CIR = 10, SIR = 11, E1I = 12, PIR = 13, E2I = 14, UIR = 15;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_op = 2'd0;
    logic [LEN_W-1:0]  cmd_len = '0;
    logic [DATA_W-1:0] cmd_data = '0;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              busy, synced, tck, tms, tdi, tdo;

    int checks = 0;
    int errors = 0;

    jtag_host_driver #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy), .synced(synced),
        .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
    );

    always #5 clk = ~clk;

    // ---- TAP target model ----
    int          tap = TLR;
    int          dr_shifts = 0;
    logic [31:0] dr_sr, dr_upd, dr_cap;
    logic [3:0]  ir_sr, ir;

    assign tdo = (tap == SDR) ? dr_sr[0] : (tap == SIR) ? ir_sr[0] : 1'b0;

    function automatic int next_tap(input int s, input logic m);
        case (s)
            TLR: return m ? TLR : RTI;
            RTI: return m ? SDS : RTI;
            SDS: return m ? SIS : CDR;
            CDR: return m ? E1D : SDR;
            SDR: return m ? E1D : SDR;
            E1D: return m ? UDR : PDR;
            PDR: return m ? E2D : PDR;
            E2D: return m ? UDR : SDR;
            UDR: return m ? SDS : RTI;
            SIS: return m ? TLR : CIR;
            CIR: return m ? E1I : SIR;
            SIR: return m ? E1I : SIR;
            E1I: return m ? UIR : PIR;
            PIR: return m ? E2I : PIR;
            E2I: return m ? UIR : SIR;
            default: return m ? SDS : RTI;
        endcase
    endfunction

    always @(posedge tck) begin
        case (tap)
            CDR: dr_sr <= dr_cap;
            SDR: begin dr_sr <= {tdi, dr_sr[31:1]}; dr_shifts <= dr_shifts + 1; end
            UDR: dr_upd <= dr_sr;
            CIR: ir_sr <= 4'b0001;
            SIR: ir_sr <= {tdi, ir_sr[3:1]};
            UIR: ir <= ir_sr;
            default: ;
        endcase
        tap <= next_tap(tap, tms);
    end

    // ---- pin monitor: tms/tdi seen at each tck rise ----
    int   ntck = 0;
    logic tms_log [0:1023];
    logic tdi_log [0:1023];

    always @(posedge tck) begin
        tms_log[ntck % 1024] <= tms;
        tdi_log[ntck % 1024] <= tdi;
        ntck <= ntck + 1;
    end

    int cmd_base = 0;

    function automatic logic [63:0] tms_bits(input int first, input int cnt);
        logic [63:0] v = '0;
        for (int i = 0; i < cnt; i++) v[i] = tms_log[(cmd_base + first + i) % 1024];
        return v;
    endfunction

    function automatic logic [63:0] tdi_bits(input int first, input int cnt);
        logic [63:0] v = '0;
        for (int i = 0; i < cnt; i++) v[i] = tdi_log[(cmd_base + first + i) % 1024];
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one command, wait for rsp_valid; cyc = clk edges from accept to rsp, n = tck rises.
    task automatic run_cmd(input logic [1:0] op, input int len, input logic [31:0] data,
                           output int cyc, output int n);
        @(negedge clk);
        cmd_base  = ntck;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = LEN_W'(len);
        cmd_data  = data;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cyc = 0;
        while (!rsp_valid && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("rsp_seen", {63'd0, rsp_valid}, 64'd1);
        n = ntck - cmd_base;
    endtask

    initial begin
        int cyc, n, sh0, early, cnt;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tck", {63'd0, tck}, 64'd0);
        chk("rst_tms", {63'd0, tms}, 64'd1);
        chk("rst_tdi", {63'd0, tdi}, 64'd0);
        chk("rst_ready", {63'd0, cmd_ready}, 64'd1);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_rspv", {63'd0, rsp_valid}, 64'd0);
        chk("rst_rspd", {32'd0, rsp_data}, 64'd0);
        chk("rst_synced", {63'd0, synced}, 64'd0);
        @(negedge clk) rst_n = 1'b1;

        // TAP_RESET: 6 TCK, rsp 24+2 clk after accept
        run_cmd(2'd0, 0, 32'h0, cyc, n);
        chk("trst_cyc", 64'(cyc), 64'd26);
        chk("trst_ntck", 64'(n), 64'd6);
        chk("trst_tms", tms_bits(0, 6), 64'h1F);
        chk("trst_synced", {63'd0, synced}, 64'd1);
        chk("trst_rsp", {32'd0, rsp_data}, 64'd0);
        chk("trst_tap", 64'(tap), 64'(RTI));

        // SHIFT_IR len 4, data 0x5
        run_cmd(2'd1, 4, 32'h5, cyc, n);
        chk("ir_ntck", 64'(n), 64'd10);
        chk("ir_cyc", 64'(cyc), 64'd42);
        chk("ir_tms", tms_bits(0, 10), 64'h183);
        chk("ir_tdi", tdi_bits(4, 4), 64'h5);
        chk("ir_rsp", {32'd0, rsp_data}, 64'h1);
        chk("ir_target", {60'd0, ir}, 64'h5);
        chk("ir_tap", 64'(tap), 64'(RTI));

        // SHIFT_DR len 32
        dr_cap = 32'h1234_5678;
        run_cmd(2'd2, 32, 32'hA5A5_0F0F, cyc, n);
        chk("dr_ntck", 64'(n), 64'd37);
        chk("dr_cyc", 64'(cyc), 64'd150);
        chk("dr_tms", tms_bits(0, 37), 64'hC_0000_0001);
        chk("dr_rsp", {32'd0, rsp_data}, 64'h1234_5678);
        chk("dr_target", {32'd0, dr_upd}, 64'hA5A5_0F0F);

        // len 0 -> one shift bit
        dr_cap = 32'h0000_0003;
        sh0 = dr_shifts;
        run_cmd(2'd2, 0, 32'h0, cyc, n);
        chk("len0_shifts", 64'(dr_shifts - sh0), 64'd1);
        chk("len0_ntck", 64'(n), 64'd6);
        chk("len0_rsp", {32'd0, rsp_data}, 64'h1);
        chk("len0_target", {32'd0, dr_upd}, 64'h1);

        // len 40 -> clamped to 32
        dr_cap = 32'hDEAD_BEEF;
        sh0 = dr_shifts;
        run_cmd(2'd2, 40, 32'h0BAD_F00D, cyc, n);
        chk("len40_shifts", 64'(dr_shifts - sh0), 64'd32);
        chk("len40_ntck", 64'(n), 64'd37);
        chk("len40_rsp", {32'd0, rsp_data}, 64'hDEAD_BEEF);
        chk("len40_target", {32'd0, dr_upd}, 64'h0BAD_F00D);

        // RUN_IDLE len 3
        run_cmd(2'd3, 3, 32'hFFFF_FFFF, cyc, n);
        chk("idle_ntck", 64'(n), 64'd3);
        chk("idle_cyc", 64'(cyc), 64'd14);
        chk("idle_tms", tms_bits(0, 3), 64'h0);
        chk("idle_tdi", tdi_bits(0, 3), 64'h0);
        chk("idle_rsp", {32'd0, rsp_data}, 64'h0);
        chk("idle_tap", 64'(tap), 64'(RTI));

        // cmd_valid held through a DR shift; second command waits for completion
        dr_cap = 32'h0000_00C3;
        @(negedge clk);
        cmd_base  = ntck;
        cmd_valid = 1'b1;
        cmd_op    = 2'd2;
        cmd_len   = LEN_W'(8);
        cmd_data  = 32'h0;
        @(posedge clk); #1;
        cmd_op  = 2'd3;
        cmd_len = LEN_W'(2);
        early = 0;
        cyc = 0;
        while (!rsp_valid && cyc < 1000) begin
            if (cmd_ready) early++;
            @(posedge clk); #1;
            cyc++;
        end
        chk("hold_rsp1", {63'd0, rsp_valid}, 64'd1);
        chk("hold_cyc1", 64'(cyc), 64'd54);
        chk("hold_early", 64'(early), 64'd0);
        chk("hold_data1", {32'd0, rsp_data}, 64'hC3);
        chk("hold_ready", {63'd0, cmd_ready}, 64'd1);
        chk("hold_tck", {63'd0, tck}, 64'd0);
        @(posedge clk); #1;
        chk("hold_accept2", {63'd0, busy}, 64'd1);
        cmd_valid = 1'b0;
        cyc = 0;
        while (!rsp_valid && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("hold_rsp2", {63'd0, rsp_valid}, 64'd1);
        chk("hold_cyc2", 64'(cyc), 64'd10);
        chk("hold_ntck", 64'(ntck - cmd_base), 64'd15);

        // Reset in the middle of a DR shift
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 2'd2;
        cmd_len   = LEN_W'(32);
        cmd_data  = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("mid_tdi_pre", {63'd0, tdi}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_tck", {63'd0, tck}, 64'd0);
        chk("arst_tms", {63'd0, tms}, 64'd1);
        chk("arst_tdi", {63'd0, tdi}, 64'd0);
        chk("arst_synced", {63'd0, synced}, 64'd0);
        chk("arst_busy", {63'd0, busy}, 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        cnt = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (rsp_valid) cnt++;
        end
        chk("arst_no_rsp", 64'(cnt), 64'd0);
        run_cmd(2'd0, 0, 32'h0, cyc, n);
        chk("arst_trst_cyc", 64'(cyc), 64'd26);
        chk("arst_trst_synced", {63'd0, synced}, 64'd1);
        chk("arst_trst_tap", 64'(tap), 64'(RTI));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
